// File: rtl/piano_voice_sched.sv
// Two-voice piano scheduler: synchronises and debounces eight active-low keys,
// queues presses and allocates them to two sine voices with retrigger/steal and release tails.
module piano_voice_sched #(
  parameter int unsigned DEBOUNCE    = 240000,
  parameter int unsigned RELEASE_CYC = 1200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_n,
  output logic [31:0] voice0_M,
  output logic [31:0] voice1_M,
  output logic        voice0_en,
  output logic        voice1_en,
  output logic [7:0]  pend
);

  localparam int unsigned DbW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned RelW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE - 1);
  localparam logic [RelW-1:0] RelLast = RelW'(RELEASE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRelease} voice_st_e;

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      acc_q, acc_d;
  logic [DbW-1:0]  db_cnt_q [8];
  logic [DbW-1:0]  db_cnt_d [8];
  logic [7:0]      press_evt, rel_evt;
  logic [7:0]      pend_q, pend_d;
  logic            serve_vld;
  logic [2:0]      serve_key;
  logic [7:0]      serve_mask;

  voice_st_e       st_q [2];
  voice_st_e       st_d [2];
  logic [2:0]      key_q [2];
  logic [2:0]      key_d [2];
  logic [RelW-1:0] rcnt_q [2];
  logic [RelW-1:0] rcnt_d [2];
  logic            oldest_q, oldest_d;
  logic            chosen;
  logic [1:0]      en_d;
  logic [31:0]     m_d [2];

  function automatic logic [31:0] note_m(input logic [2:0] idx);
    logic [31:0] m;
    case (idx)
      3'd0: m = 32'd93664;
      3'd1: m = 32'd105130;
      3'd2: m = 32'd118008;
      3'd3: m = 32'd125024;
      3'd4: m = 32'd140336;
      3'd5: m = 32'd157520;
      3'd6: m = 32'd176809;
      3'd7: m = 32'd187324;
      default: m = 32'd0;
    endcase
    return m;
  endfunction

  // Counter only runs while the synchronised level disagrees with the accepted level.
  always_comb begin
    acc_d     = acc_q;
    press_evt = '0;
    rel_evt   = '0;
    for (int k = 0; k < 8; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != acc_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          acc_d[k]     = sync2_q[k];
          press_evt[k] = ~sync2_q[k];
          rel_evt[k]   = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    serve_vld = 1'b0;
    serve_key = '0;
    for (int k = 7; k >= 0; k--) begin
      if (pend_q[k]) begin
        serve_vld = 1'b1;
        serve_key = 3'(k);
      end
    end
    serve_mask = serve_vld ? (8'b1 << serve_key) : 8'b0;
    pend_d     = (pend_q & ~serve_mask) | press_evt;
  end

  // Allocation priority: retrigger same key, then lowest idle voice, then steal the oldest.
  always_comb begin
    if (st_q[0] != StIdle && key_q[0] == serve_key) begin
      chosen = 1'b0;
    end else if (st_q[1] != StIdle && key_q[1] == serve_key) begin
      chosen = 1'b1;
    end else if (st_q[0] == StIdle) begin
      chosen = 1'b0;
    end else if (st_q[1] == StIdle) begin
      chosen = 1'b1;
    end else begin
      chosen = oldest_q;
    end
    oldest_d = serve_vld ? ~chosen : oldest_q;
  end

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      st_d[v]   = st_q[v];
      key_d[v]  = key_q[v];
      rcnt_d[v] = rcnt_q[v];
      case (st_q[v])
        StHold: begin
          if (rel_evt[key_q[v]]) begin
            st_d[v]   = StRelease;
            rcnt_d[v] = '0;
          end
        end
        StRelease: begin
          if (rcnt_q[v] == RelLast) begin
            st_d[v]   = StIdle;
            rcnt_d[v] = '0;
          end else begin
            rcnt_d[v] = rcnt_q[v] + RelW'(1);
          end
        end
        default: ;
      endcase
      // A served press overrides a same-cycle release of that key.
      if (serve_vld && chosen == 1'(v)) begin
        st_d[v]   = StHold;
        key_d[v]  = serve_key;
        rcnt_d[v] = '0;
      end
      en_d[v] = (st_d[v] != StIdle);
      m_d[v]  = en_d[v] ? note_m(key_d[v]) : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 8'hff;
      sync2_q  <= 8'hff;
      acc_q    <= 8'hff;
      pend_q   <= '0;
      oldest_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        db_cnt_q[k] <= '0;
      end
      for (int v = 0; v < 2; v++) begin
        st_q[v]   <= StIdle;
        key_q[v]  <= '0;
        rcnt_q[v] <= '0;
      end
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      oldest_q <= oldest_d;
      for (int k = 0; k < 8; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
      for (int v = 0; v < 2; v++) begin
        st_q[v]   <= st_d[v];
        key_q[v]  <= key_d[v];
        rcnt_q[v] <= rcnt_d[v];
      end
    end
  end

  // Outputs are registered from next-state so they land on the same edge as the voice update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voice0_en <= 1'b0;
      voice1_en <= 1'b0;
      voice0_M  <= '0;
      voice1_M  <= '0;
      pend      <= '0;
    end else begin
      voice0_en <= en_d[0];
      voice1_en <= en_d[1];
      voice0_M  <= m_d[0];
      voice1_M  <= m_d[1];
      pend      <= pend_d;
    end
  end

endmodule

// File: tb/tb_piano_voice_sched.sv
// Random and directed key stimulus against a per-edge reference model; expected outputs
// are queued by the driver and popped/compared by an independent negedge monitor.
module tb_piano_voice_sched;

  localparam int D  = 4;
  localparam int RC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_n;
  logic [31:0] voice0_M, voice1_M;
  logic        voice0_en, voice1_en;
  logic [7:0]  pend;

  piano_voice_sched #(
    .DEBOUNCE    (D),
    .RELEASE_CYC (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .voice0_M  (voice0_M),
    .voice1_M  (voice1_M),
    .voice0_en (voice0_en),
    .voice1_en (voice1_en),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        e0;
    logic [31:0] m0;
    logic        e1;
    logic [31:0] m1;
    logic [7:0]  pend;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  int unsigned note_tab [8] = '{93664, 105130, 118008, 125024, 140336, 157520, 176809, 187324};

  // Reference model: voice states 0=idle 1=hold 2=release; order[0] is least recently assigned.
  logic [7:0] raw_cur;
  logic [7:0] hist [$];
  logic [7:0] m_acc;
  logic [7:0] m_pend;
  int         m_st [2];
  int         m_key [2];
  int         m_rel_edge [2];
  int         order [$];
  int         t;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(8'hff);
    m_acc  = 8'hff;
    m_pend = 8'h00;
    for (int v = 0; v < 2; v++) begin
      m_st[v] = 0; m_key[v] = 0; m_rel_edge[v] = 0;
    end
    order.delete();
    order.push_back(0);
    order.push_back(1);
    t = 0;
  endtask

  task automatic model_step();
    int served, chosen;
    logic [7:0] press, rel, h;
    logic differ;
    exp_t e;
    t++;
    hist.push_front(raw_cur);
    void'(hist.pop_back());
    served = -1;
    for (int k = 7; k >= 0; k--) if (m_pend[k]) served = k;
    press = '0;
    rel   = '0;
    // A key flips once the last D synchronised samples (raw delayed by 2) all disagree with it.
    for (int k = 0; k < 8; k++) begin
      differ = 1'b1;
      for (int i = 0; i < D; i++) begin
        h = hist[2 + i];
        if (h[k] == m_acc[k]) differ = 1'b0;
      end
      if (differ) begin
        if (m_acc[k]) press[k] = 1'b1; else rel[k] = 1'b1;
        m_acc[k] = ~m_acc[k];
      end
    end
    chosen = -1;
    if (served >= 0) begin
      for (int v = 0; v < 2; v++) if (chosen < 0 && m_st[v] != 0 && m_key[v] == served) chosen = v;
      for (int v = 0; v < 2; v++) if (chosen < 0 && m_st[v] == 0) chosen = v;
      if (chosen < 0) chosen = order[0];
      m_pend[served] = 1'b0;
    end
    m_pend = m_pend | press;
    for (int v = 0; v < 2; v++) begin
      if (m_st[v] == 2 && t - m_rel_edge[v] >= RC) m_st[v] = 0;
      else if (m_st[v] == 1 && rel[m_key[v]]) begin
        m_st[v] = 2;
        m_rel_edge[v] = t;
      end
    end
    if (chosen >= 0) begin
      m_st[chosen]  = 1;
      m_key[chosen] = served;
      if (order[0] == chosen) begin
        order.delete(0);
        order.push_back(chosen);
      end
    end
    e.e0   = (m_st[0] != 0);
    e.m0   = e.e0 ? note_tab[m_key[0]] : 32'd0;
    e.e1   = (m_st[1] != 0);
    e.m1   = e.e1 ? note_tab[m_key[1]] : 32'd0;
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic do_cycle(input logic [7:0] raw);
    @(posedge clk);
    if (!rst) model_step();
    #2;
    key_n   = raw;
    raw_cur = raw;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (voice0_en !== 1'b0 || voice1_en !== 1'b0 || voice0_M !== 32'd0 ||
        voice1_M !== 32'd0 || pend !== 8'd0) begin
      n_errors++;
      $display("FAIL %s: got en0=%b en1=%b M0=%0d M1=%0d pend=%h, required all zero",
               name, voice0_en, voice1_en, voice0_M, voice1_M, pend);
    end
  endtask

  // Asserted mid-cycle: outputs must clear without any clock edge.
  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (voice0_en !== e.e0 || voice0_M !== e.m0) begin
        n_errors++;
        $display("FAIL voice0 @%0t: got en=%b M=%0d, expected en=%b M=%0d",
                 $time, voice0_en, voice0_M, e.e0, e.m0);
      end
      n_checks++;
      if (voice1_en !== e.e1 || voice1_M !== e.m1) begin
        n_errors++;
        $display("FAIL voice1 @%0t: got en=%b M=%0d, expected en=%b M=%0d",
                 $time, voice1_en, voice1_M, e.e1, e.m1);
      end
      n_checks++;
      if (pend !== e.pend) begin
        n_errors++;
        $display("FAIL pend @%0t: got %h, expected %h", $time, pend, e.pend);
      end
    end
  end

  initial begin
    logic [7:0] raw;
    rst     = 1'b1;
    key_n   = 8'hff;
    raw_cur = 8'hff;
    model_reset();
    #1;
    check_zero("reset_state");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    repeat (5) do_cycle(8'hff);
    // Single press of key 0, then release and let the tail expire.
    repeat (20) do_cycle(8'hfe);
    repeat (30) do_cycle(8'hff);
    // Bouncing key 3 never settles long enough to be accepted.
    for (int i = 0; i < 20; i++) do_cycle(((i / 2) % 2 == 0) ? 8'hf7 : 8'hff);
    repeat (10) do_cycle(8'hff);
    // Keys 2 and 5 together.
    repeat (20) do_cycle(8'hdb);
    repeat (30) do_cycle(8'hff);
    // Keys 0 and 1 held, then key 7 steals the oldest voice.
    repeat (15) do_cycle(8'hfc);
    repeat (15) do_cycle(8'h7c);
    pulse_reset();
    repeat (20) do_cycle(8'hff);
    // Key 4 released then pressed again during its release tail.
    repeat (15) do_cycle(8'hef);
    repeat (4) do_cycle(8'hff);
    repeat (20) do_cycle(8'hef);
    repeat (30) do_cycle(8'hff);
    // Key 4 released with no retrigger: full release tail.
    repeat (15) do_cycle(8'hef);
    repeat (30) do_cycle(8'hff);

    raw = 8'hff;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 13) == 0) raw[k] = ~raw[k];
      end
      do_cycle(raw);
      if (i == 1500) pulse_reset();
    end
    repeat (40) do_cycle(8'hff);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
